aes_inv_keyschedule: RTL and testbench

AES_INV_KEYSCHEDULE -- requirements
Module: aes_inv_keyschedule

---
 rtl/aes_inv_keyschedule_if.sv | 44 ++++
 rtl/aes_inv_keyschedule.sv | 224 ++++++++++++++++++++++
 tb/tb_aes_inv_keyschedule.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_keyschedule_if.sv
// aes_inv_keyschedule_if
//   Request/response bundle for the AES-128 inverse key schedule.
//   master : consumer side (drives start, last_key, next)
//   slave  : key-schedule side (drives round_key, round_idx, valid, done)
//   start     - load last_key and begin a pass (IDLE only)
//   last_key  - round-10 key, [127:120] = byte 0 of w40
//   next      - consumer accepts the current round_key
//   round_key - current round key, same byte order as last_key
//   round_idx - round number of round_key, 10 down to 0
//   valid     - round_key/round_idx stable and valid
//   done      - one-cycle pulse after round 0 is accepted
//   bundle, bundle_valid - all 11 round keys in forward-expansion layout,
//                          present only with AES_INV_KS_BUNDLE_EN defined
interface aes_inv_keyschedule_if;
    logic           start;
    logic [127:0]   last_key;
    logic           next;
    logic [127:0]   round_key;
    logic [3:0]     round_idx;
    logic           valid;
    logic           done;
`ifdef AES_INV_KS_BUNDLE_EN
    logic [1407:0]  bundle;
    logic           bundle_valid;

    modport master (
        output start, last_key, next,
        input  round_key, round_idx, valid, done, bundle, bundle_valid
    );
    modport slave (
        input  start, last_key, next,
        output round_key, round_idx, valid, done, bundle, bundle_valid
    );
`else
    modport master (
        output start, last_key, next,
        input  round_key, round_idx, valid, done
    );
    modport slave (
        input  start, last_key, next,
        output round_key, round_idx, valid, done
    );
`endif
endinterface

// File: rtl/aes_inv_keyschedule.sv
// aes_inv_keyschedule
//   Walks the AES-128 key schedule backwards, from the round-10 key down to
//   the cipher key, presenting one round key at a time under a valid/next
//   handshake. Each step costs two cycles: XOR recovers words 1..3 of the
//   previous round key, SUB recovers word 0 through SubWord(RotWord()).
//
//   Ports:
//     clk - clock, all state updates on posedge
//     rst - asynchronous active-high reset
//     ks  - aes_inv_keyschedule_if.slave (start/last_key/next in,
//           round_key/round_idx/valid/done out)
//
//   Optional feature macro: AES_INV_KS_BUNDLE_EN
//     Adds ks.bundle[1407:0] (all round keys, round 0 at the MSBs) and
//     ks.bundle_valid (set with done, cleared on start or rst).

// Combinational AES S-box, table lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module aes_inv_keyschedule (
    input  logic                  clk,
    input  logic                  rst,
    aes_inv_keyschedule_if.slave  ks
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        XOR  = 2'd2,
        SUB  = 2'd3
    } state_t;

    state_t         state, state_nx;

    logic [127:0]   key_q;
    logic [3:0]     idx_q;
    logic           done_q;
    logic [31:0]    k1_q, k2_q, k3_q;

    logic           load;       // IDLE start accepted this cycle
    logic           fin;        // final handshake (round 0 accepted)
    logic           valid;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot;
    logic [31:0]    sub;
    logic [7:0]     rcon;
    logic [31:0]    k0;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        fin      = 1'b0;
        valid    = 1'b0;
        case (state)
            IDLE: begin
                if (ks.start) begin
                    load     = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                valid = 1'b1;
                if (ks.next) begin
                    if (idx_q == 4'd0) begin
                        // Final round accepted; any start this cycle is
                        // dropped because it is only looked at in IDLE.
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = XOR;
                    end
                end
            end
            XOR:     state_nx = SUB;
            SUB:     state_nx = HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round constant for the step from round idx_q to idx_q-1
    // ------------------------------------------------------------------
    always_comb begin
        rcon = 8'h00;
        case (idx_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // SubWord(RotWord(k3)); k3 is the last word of the previous round key
    // ------------------------------------------------------------------
    assign rot = {k3_q[23:0], k3_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    assign k0 = w0 ^ sub ^ {rcon, 24'h0};

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            k1_q   <= '0;
            k2_q   <= '0;
            k3_q   <= '0;
        end else begin
            done_q <= fin;
            if (load) begin
                key_q <= ks.last_key;
                idx_q <= 4'd10;
            end
            if (state == XOR) begin
                // w[i-4] = w[i] ^ w[i-1] for the three non-leading words
                k3_q <= w3 ^ w2;
                k2_q <= w2 ^ w1;
                k1_q <= w1 ^ w0;
            end
            if (state == SUB) begin
                key_q <= {k0, k1_q, k2_q, k3_q};
                idx_q <= idx_q - 4'd1;
            end
        end
    end

    assign ks.round_key = key_q;
    assign ks.round_idx = idx_q;
    assign ks.valid     = valid;
    assign ks.done      = done_q;

`ifdef AES_INV_KS_BUNDLE_EN
    // ------------------------------------------------------------------
    // Collected key bundle: slot for round r is bundle[1407-128*r -: 128],
    // written on every entry to HOLD (load and each SUB completion).
    // ------------------------------------------------------------------
    logic [1407:0]  bundle_q;
    logic           bundle_valid_q;
    logic [3:0]     idx_dec;
    logic [10:0]    slot_hi;

    assign idx_dec = idx_q - 4'd1;
    assign slot_hi = 11'd1407 - {idx_dec, 7'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q       <= '0;
            bundle_valid_q <= 1'b0;
        end else begin
            if (load) begin
                bundle_q[127:0] <= ks.last_key;
                bundle_valid_q  <= 1'b0;
            end
            if (state == SUB)
                bundle_q[slot_hi -: 128] <= {k0, k1_q, k2_q, k3_q};
            if (fin)
                bundle_valid_q <= 1'b1;
        end
    end

    assign ks.bundle       = bundle_q;
    assign ks.bundle_valid = bundle_valid_q;
`endif

endmodule

// File: tb/tb_aes_inv_keyschedule.sv
// tb_aes_inv_keyschedule
//   Directed + randomized bench for aes_inv_keyschedule. The reference
//   model derives the S-box from GF(2^8) inversion plus the affine map and
//   walks the key expansion recurrence backwards over a word array.
module tb_aes_inv_keyschedule;
    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_inv_keyschedule_if ifc ();

    aes_inv_keyschedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ifc.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] rk_m [0:10];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subrot(input logic [31:0] x);
        logic [31:0] r;
        r = {x[23:0], x[31:24]};
        return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    endfunction

    // Fill rk_m[0..10] from a round-10 key by inverting
    // w[j] = w[j-4] ^ (j%4==0 ? SubWord(RotWord(w[j-1]))^Rcon(j/4) : w[j-1]).
    task automatic model(input logic [127:0] k10);
        logic [31:0] w [0:43];
        logic [7:0]  rc [1:10];
        logic [31:0] t;
        int j;
        rc[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
        w[40] = k10[127:96]; w[41] = k10[95:64];
        w[42] = k10[63:32];  w[43] = k10[31:0];
        for (int i = 39; i >= 0; i--) begin
            j = i + 4;
            if (j % 4 == 0) t = subrot(w[j-1]) ^ {rc[j/4], 24'h0};
            else            t = w[j-1];
            w[i] = w[j] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full pass from load to done, with stalls, an ignored start at
    // round 6, random next during XOR/SUB and optionally start alongside
    // the final handshake.
    task automatic run_pass(input logic [127:0] k, input bit fips, input bit final_start);
        int stall;
        model(k);
        ifc.start = 1'b1; ifc.last_key = k;
        tick();
        ifc.start = 1'b0; ifc.last_key = rnd128();
`ifdef AES_INV_KS_BUNDLE_EN
        chk("bundle_valid_cleared", 128'(ifc.bundle_valid), 128'(0));
`endif
        if (fips) chk("fips_r10", ifc.round_key, FIPS_K10);
        for (int r = 10; r >= 0; r--) begin
            chk("valid_hold", 128'(ifc.valid), 128'(1));
            chk("round_idx", 128'(ifc.round_idx), 128'(r));
            chk("round_key", ifc.round_key, rk_m[r]);
            if (fips && r == 9) chk("fips_r9", ifc.round_key, FIPS_K9);
            if (fips && r == 0) chk("fips_r0", ifc.round_key, FIPS_K0);
            if (r == 6) begin
                ifc.start = 1'b1; ifc.last_key = rnd128();
                tick();
                ifc.start = 1'b0;
                chk("start_ign_idx", 128'(ifc.round_idx), 128'(6));
                chk("start_ign_key", ifc.round_key, rk_m[6]);
            end
            stall = (fips && r == 10) ? 5 : int'($urandom_range(0, 2));
            repeat (stall) tick();
            chk("stall_valid", 128'(ifc.valid), 128'(1));
            chk("stall_idx", 128'(ifc.round_idx), 128'(r));
            chk("stall_key", ifc.round_key, rk_m[r]);
            ifc.next = 1'b1;
            if (r == 0 && final_start) ifc.start = 1'b1;
            tick();
            ifc.start = 1'b0;
            ifc.next  = 1'($urandom_range(0, 1));
            if (r > 0) begin
                chk("xor_valid", 128'(ifc.valid), 128'(0));
                chk("xor_done", 128'(ifc.done), 128'(0));
                tick();
                ifc.next = 1'($urandom_range(0, 1));
                chk("sub_valid", 128'(ifc.valid), 128'(0));
                tick();
                ifc.next = 1'b0;
            end else begin
                chk("done_pulse", 128'(ifc.done), 128'(1));
                chk("done_valid", 128'(ifc.valid), 128'(0));
`ifdef AES_INV_KS_BUNDLE_EN
                chk("bundle_valid", 128'(ifc.bundle_valid), 128'(1));
                for (int s = 0; s <= 10; s++)
                    chk("bundle_slot", ifc.bundle[1407-128*s -: 128], rk_m[s]);
                if (fips) chk("fips_bundle_r0", ifc.bundle[1407 -: 128], FIPS_K0);
`endif
                tick();
                ifc.next = 1'b0;
                chk("done_one_cycle", 128'(ifc.done), 128'(0));
                chk("idle_valid", 128'(ifc.valid), 128'(0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.start = 1'b0; ifc.next = 1'b0; ifc.last_key = '0;
        build_sbox();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 128'(ifc.valid), 128'(0));
        chk("rst_done", 128'(ifc.done), 128'(0));
        chk("rst_idx", 128'(ifc.round_idx), 128'(0));
        chk("rst_key", ifc.round_key, 128'(0));
`ifdef AES_INV_KS_BUNDLE_EN
        chk("rst_bundle", 128'(ifc.bundle == '0), 128'(1));
        chk("rst_bundle_valid", 128'(ifc.bundle_valid), 128'(0));
`endif
        // start on the very first edge after reset release
        rst = 1'b0;
        run_pass(FIPS_K10, 1'b1, 1'b0);

        // random passes, one with start colliding with the final handshake
        run_pass(rnd128(), 1'b0, 1'b1);
        run_pass(rnd128(), 1'b0, 1'b0);
        run_pass(rnd128(), 1'b0, 1'b1);

        // reset during SUB of round 4
        ifc.start = 1'b1; ifc.last_key = rnd128();
        tick();
        ifc.start = 1'b0; ifc.next = 1'b1;
        repeat (18) tick();
        chk("pre_rst_idx", 128'(ifc.round_idx), 128'(4));
        chk("pre_rst_valid", 128'(ifc.valid), 128'(1));
        repeat (2) tick();
        chk("sub_r4_valid", 128'(ifc.valid), 128'(0));
        ifc.next = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(ifc.valid), 128'(0));
        chk("arst_idx", 128'(ifc.round_idx), 128'(0));
        chk("arst_key", ifc.round_key, 128'(0));
        chk("arst_done", 128'(ifc.done), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", 128'(ifc.done), 128'(0));
        chk("post_rst_valid", 128'(ifc.valid), 128'(0));

        // fresh start reproduces the FIPS-197 sequence
        run_pass(FIPS_K10, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
